// File: rtl/qr_pkg.sv
// Shared types for the finder-pattern frame scheduler.
// Holds the FSM encoding, requester tags and the round-robin pick rule.
package qr_pkg;

    localparam int ADDR_W = 20;

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        RUN,
        DRAIN,
        REPORT
    } sched_state_t;

    typedef enum logic {
        REQ_H,
        REQ_V
    } req_id_t;

    typedef struct packed {
        logic    valid;
        req_id_t id;
    } rd_tag_t;

    // Winner among active requesters; on a tie the side not granted last wins.
    function automatic req_id_t rr_pick(
        input logic    h_req,
        input logic    v_req,
        input req_id_t last
    );
        if (h_req && v_req) begin
            return (last == REQ_H) ? REQ_V : REQ_H;
        end
        return h_req ? REQ_H : REQ_V;
    endfunction

endpackage

// File: rtl/rr_read_arbiter.sv
// Round-robin share of the 1-bit frame-buffer read port between two engines.
// Tags each accepted read so the returned pixel reaches the side that asked.
module rr_read_arbiter
    import qr_pkg::*;
#(
    parameter int READ_LATENCY = 2
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              enable,
    input  logic              h_req,
    input  logic [ADDR_W-1:0] h_addr,
    input  logic              v_req,
    input  logic [ADDR_W-1:0] v_addr,
    output logic              h_gnt,
    output logic              v_gnt,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              h_rvalid,
    output logic              v_rvalid,
    output logic              pending
);

    req_id_t                     last_q;
    req_id_t                     pick;
    logic                        grant_any;
    rd_tag_t [READ_LATENCY-1:0]  pipe_q;

    assign pick      = rr_pick(h_req, v_req, last_q);
    assign grant_any = enable & (h_req | v_req);
    assign h_gnt     = grant_any & (pick == REQ_H);
    assign v_gnt     = grant_any & (pick == REQ_V);

    always_comb begin
        mem_addr = '0;
        if (h_gnt) begin
            mem_addr = h_addr;
        end else if (v_gnt) begin
            mem_addr = v_addr;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            last_q <= REQ_H;
            pipe_q <= '0;
        end else begin
            if (grant_any) begin
                last_q <= pick;
            end
            pipe_q[0] <= '{valid: grant_any, id: pick};
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign h_rvalid = pipe_q[READ_LATENCY-1].valid &
                      (pipe_q[READ_LATENCY-1].id == REQ_H);
    assign v_rvalid = pipe_q[READ_LATENCY-1].valid &
                      (pipe_q[READ_LATENCY-1].id == REQ_V);

    // The output stage is being returned this cycle, so it no longer counts.
    always_comb begin
        pending = 1'b0;
        for (int i = 0; i < READ_LATENCY - 1; i++) begin
            pending = pending | pipe_q[i].valid;
        end
    end

endmodule

// File: rtl/qr_scan_scheduler.sv
// Frame sequencer for finder-pattern detection: launches both ratio engines,
// arbitrates their reads, then latches their line encodings on completion.
module qr_scan_scheduler
    import qr_pkg::*;
#(
    parameter int WIDTH          = 480,
    parameter int HEIGHT         = 480,
    parameter int READ_LATENCY   = 2,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              start_in,
    output logic              busy_out,
    output logic              done_out,
    output logic              error_out,
    output logic              h_start_out,
    output logic              v_start_out,
    input  logic              h_req_in,
    input  logic              v_req_in,
    input  logic [ADDR_W-1:0] h_addr_in,
    input  logic [ADDR_W-1:0] v_addr_in,
    output logic              h_gnt_out,
    output logic              v_gnt_out,
    output logic              h_data_out,
    output logic              v_data_out,
    output logic              h_rvalid_out,
    output logic              v_rvalid_out,
    input  logic              h_done_in,
    input  logic              v_done_in,
    input  logic [HEIGHT-1:0] h_enc_in,
    input  logic [WIDTH-1:0]  v_enc_in,
    output logic [ADDR_W-1:0] mem_addr_out,
    input  logic              mem_data_in,
    output logic [HEIGHT-1:0] h_rows_out,
    output logic [WIDTH-1:0]  v_cols_out
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    sched_state_t     state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             h_seen_q;
    logic             v_seen_q;
    logic             err_q;
    logic             h_seen_d;
    logic             v_seen_d;
    logic             run_en;
    logic             pend;

    assign run_en   = (state_q == RUN);
    assign h_seen_d = h_seen_q | h_done_in;
    assign v_seen_d = v_seen_q | v_done_in;

    assign h_data_out = mem_data_in;
    assign v_data_out = mem_data_in;

    rr_read_arbiter #(
        .READ_LATENCY(READ_LATENCY)
    ) u_arb (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .enable  (run_en),
        .h_req   (h_req_in),
        .h_addr  (h_addr_in),
        .v_req   (v_req_in),
        .v_addr  (v_addr_in),
        .h_gnt   (h_gnt_out),
        .v_gnt   (v_gnt_out),
        .mem_addr(mem_addr_out),
        .h_rvalid(h_rvalid_out),
        .v_rvalid(v_rvalid_out),
        .pending (pend)
    );

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            h_seen_q    <= 1'b0;
            v_seen_q    <= 1'b0;
            err_q       <= 1'b0;
            busy_out    <= 1'b0;
            done_out    <= 1'b0;
            error_out   <= 1'b0;
            h_start_out <= 1'b0;
            v_start_out <= 1'b0;
            h_rows_out  <= '0;
            v_cols_out  <= '0;
        end else begin
            h_start_out <= 1'b0;
            v_start_out <= 1'b0;
            done_out    <= 1'b0;
            error_out   <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start_in) begin
                        state_q     <= LAUNCH;
                        busy_out    <= 1'b1;
                        h_start_out <= 1'b1;
                        v_start_out <= 1'b1;
                    end
                end
                LAUNCH: begin
                    h_seen_q <= 1'b0;
                    v_seen_q <= 1'b0;
                    cnt_q    <= '0;
                    err_q    <= 1'b0;
                    state_q  <= RUN;
                end
                RUN: begin
                    h_seen_q <= h_seen_d;
                    v_seen_q <= v_seen_d;
                    cnt_q    <= cnt_q + CNT_W'(1);
                    // Both engines finishing wins over a simultaneous timeout.
                    if (h_seen_d && v_seen_d) begin
                        state_q <= DRAIN;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= DRAIN;
                        err_q   <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (!pend) begin
                        state_q    <= REPORT;
                        h_rows_out <= h_enc_in;
                        v_cols_out <= v_enc_in;
                        done_out   <= 1'b1;
                        error_out  <= err_q;
                        busy_out   <= 1'b0;
                    end
                end
                REPORT: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_qr_scan_scheduler.sv
// Randomised scoreboard bench for qr_scan_scheduler.
// A timestamp model predicts grants, read returns and frame completion.
`timescale 1ns/1ps
module tb_qr_scan_scheduler;
    import qr_pkg::*;

    localparam int WIDTH  = 32;
    localparam int HEIGHT = 24;
    localparam int LAT    = 2;
    localparam int TMO    = 16;

    logic              clk_in = 1'b0;
    logic              rst_in = 1'b1;
    logic              start_in = 1'b0;
    logic              busy_out, done_out, error_out;
    logic              h_start_out, v_start_out;
    logic              h_req_in = 1'b0, v_req_in = 1'b0;
    logic [ADDR_W-1:0] h_addr_in = '0, v_addr_in = '0;
    logic              h_gnt_out, v_gnt_out;
    logic              h_data_out, v_data_out;
    logic              h_rvalid_out, v_rvalid_out;
    logic              h_done_in = 1'b0, v_done_in = 1'b0;
    logic [HEIGHT-1:0] h_enc_in = '0;
    logic [WIDTH-1:0]  v_enc_in = '0;
    logic [ADDR_W-1:0] mem_addr_out;
    logic              mem_data_in = 1'b0;
    logic [HEIGHT-1:0] h_rows_out;
    logic [WIDTH-1:0]  v_cols_out;

    always #5 clk_in = ~clk_in;

    qr_scan_scheduler #(
        .WIDTH(WIDTH), .HEIGHT(HEIGHT),
        .READ_LATENCY(LAT), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk_in(clk_in), .rst_in(rst_in), .start_in(start_in),
        .busy_out(busy_out), .done_out(done_out), .error_out(error_out),
        .h_start_out(h_start_out), .v_start_out(v_start_out),
        .h_req_in(h_req_in), .v_req_in(v_req_in),
        .h_addr_in(h_addr_in), .v_addr_in(v_addr_in),
        .h_gnt_out(h_gnt_out), .v_gnt_out(v_gnt_out),
        .h_data_out(h_data_out), .v_data_out(v_data_out),
        .h_rvalid_out(h_rvalid_out), .v_rvalid_out(v_rvalid_out),
        .h_done_in(h_done_in), .v_done_in(v_done_in),
        .h_enc_in(h_enc_in), .v_enc_in(v_enc_in),
        .mem_addr_out(mem_addr_out), .mem_data_in(mem_data_in),
        .h_rows_out(h_rows_out), .v_cols_out(v_cols_out)
    );

    typedef struct {
        int      cyc;
        req_id_t id;
        logic    data;
    } rd_exp_t;

    typedef struct {
        int                cyc;
        logic              err;
        logic [HEIGHT-1:0] rows;
        logic [WIDTH-1:0]  cols;
    } done_exp_t;

    rd_exp_t   rd_q[$];
    done_exp_t dn_q[$];
    int        vectors = 0;
    int        errors  = 0;
    int        cyc     = 0;
    logic [ADDR_W-1:0] ahist [LAT];

    // Frame model: timestamps of launch, run window, last grant and done.
    bit      active = 1'b0;
    int      s = -10, run0 = -10, e = -1, done_cyc = -1, g_last = -100;
    bit      hseen, vseen, err;
    req_id_t last_gnt = REQ_H;
    bit      hg = 1'b0, vg = 1'b0;

    function automatic logic pix(input logic [ADDR_W-1:0] a);
        return a[0] ^ a[3] ^ a[9];
    endfunction

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_busy"},   64'(busy_out), 64'(0));
        check({tag, "_done"},   64'({done_out, error_out}), 64'(0));
        check({tag, "_start"},  64'({h_start_out, v_start_out}), 64'(0));
        check({tag, "_gnt"},    64'({h_gnt_out, v_gnt_out}), 64'(0));
        check({tag, "_rvalid"}, 64'({h_rvalid_out, v_rvalid_out}), 64'(0));
        check({tag, "_addr"},   64'(mem_addr_out), 64'(0));
        check({tag, "_rows"},   64'(h_rows_out), 64'(0));
        check({tag, "_cols"},   64'(v_cols_out), 64'(0));
    endtask

    // Monitor: pops expected read returns and frame completions.
    initial begin
        rd_exp_t   r;
        done_exp_t d;
        forever begin
            @(negedge clk_in);
            if (rst_in) continue;
            if (rd_q.size() != 0 && rd_q[0].cyc == cyc) begin
                r = rd_q.pop_front();
                check("rd_valid", 64'({h_rvalid_out, v_rvalid_out}),
                      64'((r.id == REQ_H) ? 2'b10 : 2'b01));
                check("rd_data",
                      64'((r.id == REQ_H) ? h_data_out : v_data_out),
                      64'(r.data));
            end else if (h_rvalid_out || v_rvalid_out) begin
                check("rd_spurious", 64'({h_rvalid_out, v_rvalid_out}), 64'(0));
            end
            if (dn_q.size() != 0 && dn_q[0].cyc == cyc) begin
                d = dn_q.pop_front();
                check("done",  64'(done_out), 64'(1));
                check("error", 64'(error_out), 64'(d.err));
                check("rows",  64'(h_rows_out), 64'(d.rows));
                check("cols",  64'(v_cols_out), 64'(d.cols));
            end else if (done_out) begin
                check("done_spurious", 64'(done_out), 64'(0));
            end
        end
    end

    task automatic model_cycle();
        bit                exp_h, exp_v, run, eb;
        logic [ADDR_W-1:0] exp_a;
        if (active && done_cyc >= 0 && cyc > done_cyc) active = 1'b0;
        eb = active && cyc > s && (done_cyc < 0 || cyc < done_cyc);
        check("busy", 64'(busy_out), 64'(eb));
        check("starts", 64'({h_start_out, v_start_out}),
              64'((active && cyc == s + 1) ? 2'b11 : 2'b00));
        run   = active && cyc >= run0 && (e < 0 || cyc <= e);
        exp_h = 1'b0;
        exp_v = 1'b0;
        exp_a = '0;
        if (run && (h_req_in || v_req_in)) begin
            if (h_req_in && v_req_in) exp_h = (last_gnt == REQ_V);
            else exp_h = h_req_in;
            exp_v    = !exp_h;
            last_gnt = exp_h ? REQ_H : REQ_V;
            exp_a    = exp_h ? h_addr_in : v_addr_in;
            rd_q.push_back('{cyc + LAT, last_gnt, pix(exp_a)});
            g_last = cyc;
        end
        check("gnt", 64'({h_gnt_out, v_gnt_out}), 64'({exp_h, exp_v}));
        check("mem_addr", 64'(mem_addr_out), 64'(exp_a));
        if (run) begin
            hseen = hseen | h_done_in;
            vseen = vseen | v_done_in;
            if (hseen && vseen) begin
                e = cyc;
                err = 1'b0;
            end else if (cyc == run0 + TMO - 1) begin
                e = cyc;
                err = 1'b1;
            end
            if (e == cyc) begin
                done_cyc = ((e + 1 > g_last + LAT) ? e + 1 : g_last + LAT) + 1;
            end
        end
        if (active && cyc == done_cyc - 1) begin
            dn_q.push_back('{done_cyc, err, h_enc_in, v_enc_in});
        end
        if (!active && start_in) begin
            active   = 1'b1;
            s        = cyc;
            run0     = cyc + 2;
            e        = -1;
            done_cyc = -1;
            g_last   = -100;
            hseen    = 1'b0;
            vseen    = 1'b0;
            err      = 1'b0;
        end
        for (int i = LAT - 1; i > 0; i--) ahist[i] = ahist[i-1];
        ahist[0] = mem_addr_out;
        hg = h_gnt_out;
        vg = v_gnt_out;
    endtask

    task automatic run_frame(input int hp, input int vp, input int hd,
                             input int vd, input bit restart,
                             input bit mid_rst, input bit fixed);
        for (int k = 0; k < 80; k++) begin
            @(posedge clk_in);
            #1;
            cyc++;
            mem_data_in = pix(ahist[LAT-1]);
            start_in    = (k == 0) || (restart && k == 6);
            h_done_in   = (k == hd + 2);
            v_done_in   = (k == vd + 2);
            h_enc_in    = HEIGHT'($urandom) | HEIGHT'(8'h80);
            v_enc_in    = WIDTH'($urandom);
            if (hg) h_req_in = 1'b0;
            if (vg) v_req_in = 1'b0;
            if (!h_req_in && $urandom_range(99) < hp) begin
                h_req_in  = 1'b1;
                h_addr_in = fixed ? ADDR_W'(5) : ADDR_W'($urandom);
            end
            if (!v_req_in && $urandom_range(99) < vp) begin
                v_req_in  = 1'b1;
                v_addr_in = ADDR_W'($urandom);
            end
            if (mid_rst && k == 8) begin
                #2 rst_in = 1'b1;
                #1;
                check_quiet("midrst");
                rd_q.delete();
                dn_q.delete();
                active   = 1'b0;
                last_gnt = REQ_H;
                hg = 1'b0;
                vg = 1'b0;
                h_req_in  = 1'b0;
                v_req_in  = 1'b0;
                start_in  = 1'b0;
                h_done_in = 1'b0;
                v_done_in = 1'b0;
                for (int i = 0; i < LAT; i++) ahist[i] = '0;
                @(negedge clk_in);
                #1 rst_in = 1'b0;
                break;
            end
            @(negedge clk_in);
            model_cycle();
            if (done_cyc >= 0 && cyc >= done_cyc + 1) break;
        end
    endtask

    initial begin
        for (int i = 0; i < LAT; i++) ahist[i] = '0;
        repeat (2) @(negedge clk_in);
        check_quiet("reset");
        #1 rst_in = 1'b0;
        // Only H requests address 5.
        run_frame(100, 0, 4, 4, 1'b0, 1'b0, 1'b1);
        // Both request every cycle.
        run_frame(100, 100, 6, 6, 1'b0, 1'b0, 1'b0);
        // Staggered completion with reads in flight.
        run_frame(100, 100, 3, 10, 1'b0, 1'b0, 1'b0);
        // V never finishes: timeout.
        run_frame(60, 60, 2, 1000, 1'b0, 1'b0, 1'b0);
        // Start re-pulsed mid-run.
        run_frame(50, 50, 5, 7, 1'b1, 1'b0, 1'b0);
        // H done during launch does not count.
        run_frame(50, 50, -1, 4, 1'b0, 1'b0, 1'b0);
        // Async reset with reads in flight.
        run_frame(100, 100, 1000, 1000, 1'b0, 1'b1, 1'b0);
        for (int f = 0; f < 40; f++) begin
            run_frame(int'($urandom_range(100)), int'($urandom_range(100)),
                      int'($urandom_range(22)) - 1,
                      int'($urandom_range(22)) - 1,
                      ($urandom_range(3) == 0), ($urandom_range(9) == 0),
                      1'b0);
        end
        @(posedge clk_in);
        #1;
        start_in  = 1'b0;
        h_done_in = 1'b0;
        v_done_in = 1'b0;
        h_req_in  = 1'b0;
        v_req_in  = 1'b0;
        repeat (6) begin
            @(posedge clk_in);
            #1 cyc++;
            mem_data_in = pix(ahist[LAT-1]);
            @(negedge clk_in);
            model_cycle();
        end
        check("rd_left", 64'(rd_q.size()), 64'(0));
        check("done_left", 64'(dn_q.size()), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog cyc=%0d got=running expected=finished", cyc);
        $fatal(1);
    end

endmodule
